// File: rtl/ham_secded_decoder.sv
// Pipelined extended-Hamming SECDED decoder: corrects single-bit errors, flags double-bit
// errors, and keeps saturating counts of both over a valid/ready stream.
module ham_secded_decoder #(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = (DATA_W <= 1)  ? 2 :
                            (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 : 6,
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_single,
    output logic              out_double,
    output logic [PAR_W-1:0]  out_pos,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    localparam int NPOS = CODE_W - 1;

    // 1-based Hamming position of data bit j: the j-th non-power-of-two position.
    function automatic int data_pos(input int j);
        int cnt;
        int r;
        cnt = 0;
        r   = 0;
        for (int p = 1; p <= NPOS; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) r = p;
                cnt++;
            end
        end
        return r;
    endfunction

    logic [2:1]        vld_pipe;
    logic              adv;
    logic [PAR_W-1:0]  syn_c;
    logic              ovp_c;
    logic [CODE_W-1:0] s1_code;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_ovp;
    logic [CODE_W-1:0] fixed_c;
    logic [DATA_W-1:0] data_c;
    logic              single_c;
    logic              double_c;
    logic [PAR_W-1:0]  pos_c;
    logic              out_hs;

    assign adv       = !vld_pipe[2] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[2];
    assign out_hs    = vld_pipe[2] && out_ready;

    always_comb begin
        syn_c = '0;
        for (int k = 0; k < PAR_W; k++) begin
            for (int i = 0; i < NPOS; i++) begin
                if ((((i + 1) >> k) & 1) != 0) syn_c[k] = syn_c[k] ^ in_code[i];
            end
        end
    end

    assign ovp_c = ^in_code;

    // Syndromes beyond the last real position can only come from multi-bit errors.
    always_comb begin
        fixed_c  = s1_code;
        single_c = 1'b0;
        double_c = 1'b0;
        pos_c    = '0;
        if (s1_syn == '0) begin
            single_c = s1_ovp;
        end else if (s1_ovp && (int'(s1_syn) <= NPOS)) begin
            single_c = 1'b1;
            pos_c    = s1_syn;
            fixed_c  = s1_code ^ (CODE_W'(1) << (s1_syn - 1'b1));
        end else begin
            double_c = 1'b1;
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_extract
        localparam int DP = data_pos(j) - 1;
        assign data_c[j] = fixed_c[DP];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe     <= '0;
            s1_code      <= '0;
            s1_syn       <= '0;
            s1_ovp       <= 1'b0;
            out_data     <= '0;
            out_syndrome <= '0;
            out_single   <= 1'b0;
            out_double   <= 1'b0;
            out_pos      <= '0;
        end else if (adv) begin
            vld_pipe     <= {vld_pipe[1], in_valid};
            s1_code      <= in_code;
            s1_syn       <= syn_c;
            s1_ovp       <= ovp_c;
            out_data     <= data_c;
            out_syndrome <= s1_syn;
            out_single   <= single_c;
            out_double   <= double_c;
            out_pos      <= pos_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (out_hs) begin
            if (out_single && (cnt_corr != '1))   cnt_corr   <= cnt_corr + 1'b1;
            if (out_double && (cnt_uncorr != '1)) cnt_uncorr <= cnt_uncorr + 1'b1;
        end
    end

endmodule

// File: doc/ham_secded_decoder.md
Name: ham_secded_decoder

Overview:
- Parametrised, pipelined extended-Hamming (SECDED) decoder for DATA_W data bits.
- Single-bit errors are corrected and double-bit errors are detected.
- Runs a valid/ready stream with backpressure and keeps saturating error counters.
- Sits between the channel/memory read path and consumers.

Parameters:
DATA_W, 4, data bits per word (1..57).
PAR_W, derived (localparam), smallest p with 2^p >= DATA_W+p+1; 3 for DATA_W=4.
CODE_W, derived (localparam), DATA_W+PAR_W+1; 8 for DATA_W=4.
CNT_W, 16, width of each error counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  codeword on in_code is valid.
in_ready  output  1  decoder accepts the codeword this cycle.
in_code  input  CODE_W  received codeword.
out_valid  output  1  decoded result valid.
out_ready  input  1  consumer accepts the result.
out_data  output  DATA_W  corrected data.
out_syndrome  output  PAR_W  raw Hamming syndrome.
out_single  output  1  one error was corrected.
out_double  output  1  uncorrectable error; out_data is uncorrected.
out_pos  output  PAR_W  1-based position of the corrected bit; 0 if none or overall-parity bit.
cnt_clr  input  1  synchronous clear of both counters.
cnt_corr  output  CNT_W  saturating count of out_single results.
cnt_uncorr  output  CNT_W  saturating count of out_double results.

Behaviour:
- Codeword layout:
  - in_code[i] holds Hamming position i+1 for i < CODE_W-1.
  - Positions 2^k are parity bits; the others hold data bits in ascending order, LSB first.
  - in_code[CODE_W-1] is overall even parity over all other bits.
  - For DATA_W=4 this is d0@[2], d1@[4], d2@[5], d3@[6], p1@[0], p2@[1], p4@[3].
- Syndrome: bit k = XOR of all positions whose index has bit k set. Overall-parity check ovp = XOR of all CODE_W bits.
- Classification:
  - syn=0, ovp=0: clean.
  - syn=0, ovp=1: overall-parity bit in error. out_single=1, out_pos=0, data unchanged.
  - syn!=0, ovp=1, syn<=CODE_W-1: flip position syn. out_single=1, out_pos=syn.
  - syn!=0, ovp=1, syn>CODE_W-1: out_double=1, out_pos=0.
  - syn!=0, ovp=0: out_double=1, out_pos=0, data is raw extraction.
  - out_single and out_double are never both 1.
- Pipeline:
  - Stage 1 registers the codeword, syn and ovp.
  - Stage 2 registers the corrected data and flags.
  - Latency is 2 cycles from input handshake to out_valid at full throughput: 1 word/cycle.
  - adv = !out_valid || out_ready; in_ready = adv. in_ready is combinational from out_ready and state, with no dependence on in_valid.
  - When adv=1, both stages shift. Stage 1 valid <= in_valid; stage 2 takes stage 1.
  - When adv=0, all registers hold. Bubbles are retained in order (no collapse).
  - While out_valid=1 and out_ready=0, out_* are stable.
- Counters:
  - Increment once per output handshake (out_valid && out_ready) carrying out_single / out_double.
  - Saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr has priority over a same-cycle increment; the result is 0.
- Reset: out_valid=0, stage-1 valid=0, out_data=0, out_syndrome=0, out_single=0, out_double=0, out_pos=0, cnt_corr=0, cnt_uncorr=0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-stream discards in-flight words with no output.

Test Plan:
- DATA_W=4, in_code=8'h55 (data 4'hB), out_ready=1: 2 cycles later out_data=4'hB, out_syndrome=0, out_single=0, out_double=0, counters unchanged.
- in_code=8'h45 (bit 4, position 5, flipped): out_data=4'hB, out_syndrome=5, out_pos=5, out_single=1, cnt_corr=1.
- in_code=8'hD5 (overall bit flipped): out_data=4'hB, out_syndrome=0, out_pos=0, out_single=1.
- in_code=8'h47 (positions 5 and 2 flipped): out_syndrome=7, out_double=1, out_data=4'h9, cnt_uncorr=1.
- Backpressure:
  - Stream 8'h55, 8'h45, 8'h47 back-to-back while out_ready is held 0 for 3 cycles.
  - Required: in_ready=0 once both stages are full, outputs held stable, and order and values preserved after release.
- Counter edges:
  - CNT_W=2: 5 corrected words give cnt_corr=3 (saturated).
  - cnt_clr coinciding with a corrected output handshake gives cnt_corr=0.
  - rst asserted with 2 words in flight gives out_valid=0 the next cycle and no output appears.
